// File: rtl/chacha_block_engine.sv
// ChaCha block function core: QR_PAR quarter-round units per cycle over ROUNDS rounds,
// feed-forward add, valid/ready output. Optional multi-block bursts under CHACHA_BURST_EN.
module chacha_block_engine #(
    parameter int ROUNDS    = 20,
    parameter int QR_PAR    = 1,
    parameter int BLK_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [511:0]         state_in,
`ifdef CHACHA_BURST_EN
    input  logic [7:0]           burst_len,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [511:0]         block_out,
    output logic                 busy,
    output logic [BLK_CNT_W-1:0] blocks_produced
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_ADD   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] DR_LAST = 4'(ROUNDS / 2 - 1);
    localparam logic [1:0] QR_STEP = 2'(QR_PAR);
    localparam logic [1:0] QR_LAST = 2'(4 - QR_PAR);

    if (ROUNDS != 8 && ROUNDS != 12 && ROUNDS != 20) begin : g_bad_rounds
        $error("chacha_block_engine: ROUNDS must be 8, 12 or 20");
    end
    if (QR_PAR != 1 && QR_PAR != 2 && QR_PAR != 4) begin : g_bad_qr_par
        $error("chacha_block_engine: QR_PAR must be 1, 2 or 4");
    end

    function automatic logic [127:0] quarter_round(
        input logic [31:0] a_in,
        input logic [31:0] b_in,
        input logic [31:0] c_in,
        input logic [31:0] d_in
    );
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        a = a_in;
        b = b_in;
        c = c_in;
        d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // Word index of one QR operand: row = role, diagonal QRs shift the column by the row.
    function automatic logic [3:0] word_idx(
        input logic       diag,
        input logic [1:0] qi,
        input logic [1:0] role
    );
        logic [1:0] col;
        if (diag) begin
            col = qi + role;
        end else begin
            col = qi;
        end
        return {role, col};
    endfunction

    logic [1:0]        r_state;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_out_valid;
    logic [15:0][31:0] r_block_out;
    logic [BLK_CNT_W-1:0] r_blk_cnt;
    logic [15:0][31:0] r_init;
    logic [15:0][31:0] r_work;
    logic [1:0]        r_qr_idx;
    logic              r_diag;
    logic [3:0]        r_dround;

    logic [15:0][31:0] w_work_nxt;
    logic [15:0][31:0] w_sum;
    logic [15:0][31:0] w_init_bump;
    logic [1:0]        w_qi;
    logic [3:0]        w_ia;
    logic [3:0]        w_ib;
    logic [3:0]        w_ic;
    logic [3:0]        w_id;
    logic [127:0]      w_qr_res;
    logic              w_half_end;
    logic              w_last_step;
    logic              w_more_blocks;

    // Apply this cycle's QR_PAR quarter-rounds; they touch disjoint words so all read r_work.
    always_comb begin
        w_work_nxt = r_work;
        w_qi       = 2'd0;
        w_ia       = 4'd0;
        w_ib       = 4'd0;
        w_ic       = 4'd0;
        w_id       = 4'd0;
        w_qr_res   = 128'd0;
        for (int k = 0; k < QR_PAR; k++) begin
            w_qi     = r_qr_idx + 2'(k);
            w_ia     = word_idx(r_diag, w_qi, 2'd0);
            w_ib     = word_idx(r_diag, w_qi, 2'd1);
            w_ic     = word_idx(r_diag, w_qi, 2'd2);
            w_id     = word_idx(r_diag, w_qi, 2'd3);
            w_qr_res = quarter_round(r_work[w_ia], r_work[w_ib], r_work[w_ic], r_work[w_id]);
            w_work_nxt[w_ia] = w_qr_res[127:96];
            w_work_nxt[w_ib] = w_qr_res[95:64];
            w_work_nxt[w_ic] = w_qr_res[63:32];
            w_work_nxt[w_id] = w_qr_res[31:0];
        end
    end

    // Feed-forward sum and the next-block initial state with word 12 bumped (no carry).
    always_comb begin
        w_sum       = r_work;
        w_init_bump = r_init;
        for (int i = 0; i < 16; i++) begin
            w_sum[i] = r_init[i] + r_work[i];
        end
        w_init_bump[12] = r_init[12] + 32'd1;
    end

    assign w_half_end  = (r_qr_idx == QR_LAST);
    assign w_last_step = w_half_end && r_diag && (r_dround == DR_LAST);

`ifdef CHACHA_BURST_EN
    logic [7:0] r_burst_left;

    assign w_more_blocks = (r_burst_left > 8'd1);

    // Blocks still owed for the current input; a zero length request yields one block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst_left <= 8'd0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_burst_left <= (burst_len == 8'd0) ? 8'd1 : burst_len;
        end else if (r_state == S_DONE && out_ready && w_more_blocks) begin
            r_burst_left <= r_burst_left - 8'd1;
        end else begin
            r_burst_left <= r_burst_left;
        end
    end
`else
    assign w_more_blocks = 1'b0;
`endif

    // Main FSM with its datapath registers and handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_block_out <= '0;
            r_blk_cnt   <= '0;
            r_init      <= '0;
            r_work      <= '0;
            r_qr_idx    <= 2'd0;
            r_diag      <= 1'b0;
            r_dround    <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_init     <= state_in;
                        r_work     <= state_in;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_work   <= w_work_nxt;
                    r_qr_idx <= r_qr_idx + QR_STEP;
                    if (w_last_step) begin
                        r_diag   <= 1'b0;
                        r_dround <= 4'd0;
                        r_state  <= S_ADD;
                    end else if (w_half_end) begin
                        r_diag   <= ~r_diag;
                        r_dround <= r_diag ? (r_dround + 4'd1) : r_dround;
                    end
                end
                S_ADD: begin
                    r_block_out <= w_sum;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_blk_cnt   <= r_blk_cnt + BLK_CNT_W'(1);
                        if (w_more_blocks) begin
                            r_init  <= w_init_bump;
                            r_work  <= w_init_bump;
                            r_state <= S_ROUND;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = r_in_ready;
    assign busy            = r_busy;
    assign out_valid       = r_out_valid;
    assign block_out       = r_block_out;
    assign blocks_produced = r_blk_cnt;

endmodule

// File: tb/tb_chacha_block_engine.sv
// Bench for chacha_block_engine: three configurations driven in lockstep and compared with
// an RFC-style block function model; the burst test is built when CHACHA_BURST_EN is set.
module tb_chacha_block_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [511:0] state_in;
`ifdef CHACHA_BURST_EN
    logic [7:0]   burst_len;
`endif
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [511:0] block_out [3];
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;
    logic [7:0]   cnt_c;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    int lat [3];
    int qtab [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

    always #5 clk = ~clk;

    chacha_block_engine #(.ROUNDS(20), .QR_PAR(1), .BLK_CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .state_in(state_in),
`ifdef CHACHA_BURST_EN
        .burst_len(burst_len),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready), .block_out(block_out[0]),
        .busy(busy[0]), .blocks_produced(cnt_a));

    chacha_block_engine #(.ROUNDS(20), .QR_PAR(4), .BLK_CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .state_in(state_in),
`ifdef CHACHA_BURST_EN
        .burst_len(burst_len),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready), .block_out(block_out[1]),
        .busy(busy[1]), .blocks_produced(cnt_b));

    chacha_block_engine #(.ROUNDS(12), .QR_PAR(2), .BLK_CNT_W(8)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .state_in(state_in),
`ifdef CHACHA_BURST_EN
        .burst_len(burst_len),
`endif
        .out_valid(out_valid[2]), .out_ready(out_ready), .block_out(block_out[2]),
        .busy(busy[2]), .blocks_produced(cnt_c));

    function automatic int rounds_of(input int d);
        return (d == 2) ? 12 : 20;
    endfunction

    function automatic int latency_of(input int d);
        return (d == 0) ? 81 : ((d == 1) ? 21 : 25);
    endfunction

    function automatic logic [7:0] cnt_of(input int d);
        return (d == 0) ? cnt_a : ((d == 1) ? {6'd0, cnt_b} : cnt_c);
    endfunction

    function automatic logic [7:0] exp_cnt(input int d);
        return (d == 1) ? 8'(n_hs % 4) : 8'(n_hs % 256);
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Reference ChaCha block: alternating column/diagonal QRs from the table, then feed-forward.
    function automatic logic [511:0] ref_block(input logic [511:0] st, input int rounds);
        logic [31:0]  x [16];
        logic [511:0] res;
        int a, b, c, d;
        for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
        for (int r = 0; r < rounds; r += 2) begin
            for (int q = 0; q < 8; q++) begin
                a = qtab[q][0]; b = qtab[q][1]; c = qtab[q][2]; d = qtab[q][3];
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
            end
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + st[32*i +: 32];
        return res;
    endfunction

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [511:0] st);
        check_eq("ready_before_start", {509'd0, in_ready[0], in_ready[1], in_ready[2]}, 512'h7);
        state_in = st;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges until every engine shows out_valid, optionally poking in_valid mid-flight.
    task automatic wait_outputs(input logic [511:0] st, input logic poke);
        lat = '{0, 0, 0};
        for (int cyc = 1; cyc <= 200 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); cyc++) begin
            if (poke && cyc == 3) begin
                state_in = ~st;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            for (int d = 0; d < 3; d++) if (out_valid[d] && lat[d] == 0) lat[d] = cyc;
        end
        in_valid = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("latency_%0d", d), 512'(lat[d]), 512'(latency_of(d)));
            check_eq($sformatf("block_%0d", d), block_out[d], ref_block(st, rounds_of(d)));
        end
    endtask

    task automatic release_out(input logic exp_ready);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_hs++;
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("in_ready_after_hs_%0d", d), 512'(in_ready[d]), 512'(exp_ready));
            check_eq($sformatf("out_valid_after_hs_%0d", d), 512'(out_valid[d]), 512'd0);
            check_eq($sformatf("count_%0d", d), 512'(cnt_of(d)), 512'(exp_cnt(d)));
        end
    endtask

    function automatic logic [511:0] rand_state();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    logic [15:0][31:0] rfc_st;
    logic [15:0][31:0] zero_st;
    logic [511:0]      st;
    logic [511:0]      saved [3];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = 512'd0;
`ifdef CHACHA_BURST_EN
        burst_len = 8'd1;
`endif
        rfc_st  = {32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
                   32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                   32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
                   32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        zero_st = '0;
        zero_st[0] = 32'h61707865; zero_st[1] = 32'h3320646e;
        zero_st[2] = 32'h79622d32; zero_st[3] = 32'h6b206574;

        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("rst_in_ready_%0d", d), 512'(in_ready[d]), 512'd1);
            check_eq($sformatf("rst_out_valid_%0d", d), 512'(out_valid[d]), 512'd0);
            check_eq($sformatf("rst_busy_%0d", d), 512'(busy[d]), 512'd0);
            check_eq($sformatf("rst_block_%0d", d), block_out[d], 512'd0);
            check_eq($sformatf("rst_count_%0d", d), 512'(cnt_of(d)), 512'd0);
        end
        rst = 1'b0;
        tick();

        // RFC 8439 2.3.2 vector, with a stray in_valid while busy, then a 20-cycle stall.
        start_block(rfc_st);
        check_eq("busy_in_round", 512'(busy[0]), 512'd1);
        wait_outputs(rfc_st, 1'b1);
        for (int d = 0; d < 2; d++) begin
            saved[d] = block_out[d];
            check_eq($sformatf("rfc_word0_%0d", d), 512'(saved[d][31:0]), 512'he4e7f110);
            check_eq($sformatf("rfc_word15_%0d", d), 512'(saved[d][511:480]), 512'h4e3c50a2);
        end
        saved[2] = block_out[2];
        repeat (20) tick();
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("stall_block_%0d", d), block_out[d], saved[d]);
            check_eq($sformatf("stall_in_ready_%0d", d), 512'(in_ready[d]), 512'd0);
            check_eq($sformatf("stall_out_valid_%0d", d), 512'(out_valid[d]), 512'd1);
            check_eq($sformatf("stall_count_%0d", d), 512'(cnt_of(d)), 512'(exp_cnt(d)));
        end
        release_out(1'b1);

        // All-zero key and nonce.
        start_block(zero_st);
        wait_outputs(zero_st, 1'b0);
        check_eq("zero_word0_a", 512'(block_out[0][31:0]), 512'hade0b876);
        check_eq("zero_word0_b", 512'(block_out[1][31:0]), 512'hade0b876);
        release_out(1'b1);

        // Reset asserted 30 edges into a block, away from any clock edge.
        start_block(rand_state());
        repeat (30) tick();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("midrst_out_valid_%0d", d), 512'(out_valid[d]), 512'd0);
            check_eq($sformatf("midrst_block_%0d", d), block_out[d], 512'd0);
            check_eq($sformatf("midrst_in_ready_%0d", d), 512'(in_ready[d]), 512'd1);
        end
        tick();
        rst  = 1'b0;
        n_hs = 0;
        tick();

        // Random blocks back to back; the 2-bit counter wraps 1,2,3,0,1.
        for (int i = 0; i < 5; i++) begin
            st = rand_state();
            start_block(st);
            wait_outputs(st, 1'b0);
            release_out(1'b1);
        end

`ifdef CHACHA_BURST_EN
        // Three-block burst whose block counter wraps without touching word 13.
        st = rand_state();
        st[12*32 +: 32] = 32'hFFFFFFFE;
        burst_len = 8'd3;
        start_block(st);
        burst_len = 8'd1;
        for (int b = 0; b < 3; b++) begin
            logic [511:0] stb;
            stb = st;
            stb[12*32 +: 32] = 32'hFFFFFFFE + 32'(b);
            wait_outputs(stb, 1'b0);
            release_out(b == 2);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
